// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared types and command-word bit positions for the SPI register file.
// Contents: state_e (CMD/DATA frame decoding state), RW_BIT/INC_BIT offsets from the command MSB.
package spi_regfile_pkg;
    typedef enum logic {CMD, DATA} state_e;
    localparam int RW_BIT  = 0;
    localparam int INC_BIT = 1;
endpackage

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: SPI bit-level engine (rx/tx shift registers, bit counter, frame-done pulse).
// Ports: sclk/rst_n clock and sync active-low reset; enable freezes all state when low;
//        ss active-low select (high clears the frame); mosi serial in; tx_load/tx_load_val
//        replace the tx shift register on an active edge; miso registered serial out;
//        frame_done marks the active edge carrying the last bit; rx_word is the completed
//        word including the current mosi bit.
module spi_frame_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              ss,
    input  logic              mosi,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_load_val,
    output logic              miso,
    output logic              frame_done,
    output logic [DATA_W-1:0] rx_word
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              active;

    assign active     = enable && !ss;
    assign rx_word    = {rx_q[DATA_W-2:0], mosi};
    assign frame_done = active && (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign miso       = miso_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        if (enable && ss) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
        end else if (active) begin
            bit_cnt_d = frame_done ? '0 : bit_cnt_q + CNT_W'(1);
            rx_d      = rx_word;
            miso_d    = tx_q[DATA_W-1];
            tx_d      = tx_load ? tx_load_val : {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
        end
    end
endmodule

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI slave exposing a small register file (register 0 is a read-only ID).
// Ports: sclk/rst_n clock and sync active-low reset; enable freezes all state when low;
//        ss/mosi/miso SPI slave pins (MSB first); ctrl_regs flattened register file,
//        register i at [i*DATA_W +: DATA_W]; wr_strobe one-cycle pulse after an accepted
//        write; wr_addr address of the most recent accepted write.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(8'hA5),
    localparam int               ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       ss,
    input  logic                       mosi,
    output logic                       miso,
    output logic [NUM_REGS*DATA_W-1:0] ctrl_regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    state_e                            state_q, state_d;
    logic                              rw_q, rw_d, inc_q, inc_d;
    logic [ADDR_W-1:0]                 addr_q, addr_d, next_addr, cmd_addr;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic                              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
    logic                              tx_load, frame_done;
    logic [DATA_W-1:0]                 tx_load_val, rx_word;

    spi_frame_shifter #(.DATA_W(DATA_W)) u_shifter (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ss          (ss),
        .mosi        (mosi),
        .tx_load     (tx_load),
        .tx_load_val (tx_load_val),
        .miso        (miso),
        .frame_done  (frame_done),
        .rx_word     (rx_word)
    );

    assign ctrl_regs = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign next_addr = inc_q ? addr_q + ADDR_W'(1) : addr_q;
    assign cmd_addr  = rx_word[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        inc_d       = inc_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        wr_strobe_d = wr_strobe_q;
        wr_addr_d   = wr_addr_q;
        tx_load     = 1'b0;
        tx_load_val = '0;
        if (enable) begin
            wr_strobe_d = 1'b0;
            if (ss) begin
                state_d = CMD;
            end else if (frame_done && state_q == CMD) begin
                rw_d        = rx_word[DATA_W-1-RW_BIT];
                inc_d       = rx_word[DATA_W-1-INC_BIT];
                addr_d      = cmd_addr;
                state_d     = DATA;
                tx_load     = rx_word[DATA_W-1-RW_BIT];
                tx_load_val = regs_q[cmd_addr];
            end else if (frame_done) begin
                // Register 0 holds the ID and silently ignores writes.
                if (!rw_q && addr_q != '0) begin
                    regs_d[addr_q] = rx_word;
                    wr_addr_d      = addr_q;
                    wr_strobe_d    = 1'b1;
                end
                addr_d      = next_addr;
                tx_load     = rw_q;
                tx_load_val = regs_q[next_addr];
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q     <= CMD;
            rw_q        <= 1'b0;
            inc_q       <= 1'b0;
            addr_q      <= '0;
            regs_q      <= {{((NUM_REGS-1)*DATA_W){1'b0}}, ID_VALUE};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            inc_q       <= inc_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: directed SPI transactions checked against a frame-level model.
module tb_spi_regfile_peripheral;
    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [31:0] ctrl_regs;
    logic        wr_strobe;
    logic [1:0]  wr_addr;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    bit chk_en = 0;

    spi_regfile_peripheral #(.DATA_W(8), .NUM_REGS(4), .ID_VALUE(8'hA5)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .ctrl_regs (ctrl_regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: tracks the word being transmitted and the bit position in the frame.
    logic [7:0] mreg [4];
    logic [7:0] m_word, m_send;
    int         m_cnt, m_addr;
    bit         m_cmd, m_rw, m_inc, m_miso, m_stb;
    int         m_wa;

    task automatic m_frame(input logic [7:0] w);
        if (m_cmd) begin
            m_rw   = w[7];
            m_inc  = w[6];
            m_addr = w % 4;
            m_cmd  = 0;
        end else begin
            if (!m_rw && m_addr != 0) begin
                mreg[m_addr] = w;
                m_stb = 1;
                m_wa  = m_addr;
            end
            if (m_inc) m_addr = (m_addr + 1) % 4;
        end
        m_send = m_rw ? mreg[m_addr] : 8'h00;
    endtask

    always @(posedge sclk) begin
        if (!rst_n) begin
            mreg[0] = 8'hA5;
            for (int i = 1; i < 4; i++) mreg[i] = 8'h00;
            m_cnt = 0; m_word = 0; m_cmd = 1; m_send = 0; m_miso = 0;
            m_stb = 0; m_wa = 0; m_addr = 0; m_rw = 0; m_inc = 0;
        end else if (enable) begin
            m_stb = 0;
            if (ss) begin
                m_cnt = 0; m_word = 0; m_cmd = 1; m_send = 0; m_miso = 0;
            end else begin
                m_miso = m_send[7 - m_cnt];
                m_word = {m_word[6:0], mosi};
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    m_frame(m_word);
                end
            end
        end
    end

    always @(negedge sclk) begin
        if (chk_en) begin
            chk("miso", {31'b0, miso}, {31'b0, m_miso});
            chk("wr_strobe", {31'b0, wr_strobe}, {31'b0, m_stb});
            chk("wr_addr", {30'b0, wr_addr}, m_wa);
            chk("ctrl_regs", ctrl_regs, {mreg[3], mreg[2], mreg[1], mreg[0]});
            if (wr_strobe) stb_cnt++;
        end
    end

    task automatic xfer(input logic [7:0] w, input int nbits, input int pause_at, output logic [7:0] rx);
        rx = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at) begin
                enable = 1'b0;
                repeat (3) @(negedge sclk);
                enable = 1'b1;
            end
            mosi = w[7-i];
            @(negedge sclk);
            rx = {rx[6:0], miso};
        end
    endtask

    task automatic deselect();
        ss = 1'b1;
        repeat (2) @(negedge sclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [7:0] rx;

    initial begin
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        chk_en = 1;
        chk("reset ctrl_regs", ctrl_regs, 32'h0000_00A5);
        chk("reset miso", {31'b0, miso}, 32'd0);
        chk("reset wr_strobe", {31'b0, wr_strobe}, 32'd0);
        chk("reset wr_addr", {30'b0, wr_addr}, 32'd0);

        // single write
        stb_cnt = 0;
        ss = 1'b0;
        xfer(8'h02, 8, -1, rx);
        xfer(8'h3C, 8, -1, rx);
        deselect();
        chk("write reg2", {24'b0, ctrl_regs[23:16]}, 32'h3C);
        chk("write wr_addr", {30'b0, wr_addr}, 32'd2);
        chk("write strobe count", stb_cnt, 1);

        // read ID register
        ss = 1'b0;
        xfer(8'h80, 8, -1, rx);
        xfer(8'h00, 8, -1, rx);
        deselect();
        chk("read id", {24'b0, rx}, 32'hA5);

        // auto-increment burst wrapping through read-only register 0
        stb_cnt = 0;
        ss = 1'b0;
        xfer(8'h43, 8, -1, rx);
        xfer(8'h11, 8, -1, rx);
        xfer(8'h22, 8, -1, rx);
        xfer(8'h33, 8, -1, rx);
        deselect();
        chk("burst reg3", {24'b0, ctrl_regs[31:24]}, 32'h11);
        chk("burst reg0", {24'b0, ctrl_regs[7:0]}, 32'hA5);
        chk("burst reg1", {24'b0, ctrl_regs[15:8]}, 32'h33);
        chk("burst strobe count", stb_cnt, 2);
        chk("burst wr_addr", {30'b0, wr_addr}, 32'd1);

        // partial frame aborted by ss, then read register 1
        ss = 1'b0;
        xfer(8'h01, 8, -1, rx);
        xfer(8'hFF, 5, -1, rx);
        deselect();
        ss = 1'b0;
        xfer(8'h81, 8, -1, rx);
        xfer(8'h00, 8, -1, rx);
        deselect();
        chk("partial read reg1", {24'b0, rx}, 32'h33);

        // reset mid-burst, then first frame is a command
        ss = 1'b0;
        xfer(8'h41, 8, -1, rx);
        xfer(8'hAA, 8, -1, rx);
        xfer(8'hBB, 8, -1, rx);
        xfer(8'hCC, 3, -1, rx);
        rst_n = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        chk("rst regs", ctrl_regs, 32'h0000_00A5);
        xfer(8'h03, 8, -1, rx);
        xfer(8'h5A, 8, -1, rx);
        deselect();
        chk("post-rst cmd reg3", ctrl_regs, 32'h5A00_00A5);

        // enable pauses mid-frame on write and read
        ss = 1'b0;
        xfer(8'h01, 8, -1, rx);
        xfer(8'h77, 8, 4, rx);
        deselect();
        chk("pause write reg1", {24'b0, ctrl_regs[15:8]}, 32'h77);
        ss = 1'b0;
        xfer(8'h81, 8, -1, rx);
        xfer(8'h00, 8, 4, rx);
        deselect();
        chk("pause read reg1", {24'b0, rx}, 32'h77);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 Parameter DATA_W, default 8: SPI frame width in bits, legal range 8..32.
REQ-002 Parameter NUM_REGS, default 4: register count, power of two, 2 <= NUM_REGS <= 2^(DATA_W-2).
REQ-003 Parameter ID_VALUE, default 8'hA5 zero-extended to DATA_W: read-only content of register 0.
REQ-004 Derived constant ADDR_W = clog2(NUM_REGS).
REQ-005 sclk  input  1  sole clock; all state updates on posedge sclk.
REQ-006 rst_n  input  1  reset, synchronous, active-low; clock sclk.
REQ-007 enable  input  1  active-high; when low, all state holds.
REQ-008 ss  input  1  slave select, active-low.
REQ-009 mosi  input  1  serial data in, MSB first.
REQ-010 miso  output  1  serial data out, registered, MSB first.
REQ-011 ctrl_regs  output  NUM_REGS*DATA_W  flattened register file; register i occupies bits [i*DATA_W +: DATA_W]; slice 0 = ID_VALUE.
REQ-012 wr_strobe  output  1  high for one sclk period after each accepted write.
REQ-013 wr_addr  output  ADDR_W  address of the most recent accepted write.

Function
REQ-014 Active edge: posedge sclk with rst_n=1, enable=1, ss=0.
REQ-015 Each active edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit_cnt increments modulo DATA_W.
REQ-016 Frame completes on the active edge where bit_cnt==DATA_W-1; completed word = {rx_shift[DATA_W-2:0], mosi}, including the current mosi bit.
REQ-017 States: CMD (next frame is a command) and DATA (next frame is data); reset state is CMD.
REQ-018 Command word: bit DATA_W-1 = R(1)/W(0); bit DATA_W-2 = auto-increment; bits [ADDR_W-1:0] = address; remaining bits ignored.
REQ-019 CMD frame completion: latch rw, inc and addr; transition to DATA; on read, tx_shift <= register[addr].
REQ-020 Each active edge: miso <= tx_shift[DATA_W-1]; tx_shift <= {tx_shift[DATA_W-2:0], 1'b0}, except when loaded per REQ-019/REQ-022.
REQ-021 DATA write frame completion: if addr != 0, register[addr] <= word, wr_addr <= addr, wr_strobe <= 1; if addr == 0, write is discarded with no strobe.
REQ-022 DATA frame completion: if inc=1, addr <= (addr+1) mod NUM_REGS, wrapping NUM_REGS-1 to 0; on read, tx_shift <= register[next addr].
REQ-023 DATA persists for any number of frames until ss deasserts; no return to CMD while ss=0.
REQ-024 wr_strobe clears on the next posedge sclk that does not complete an accepted write.
REQ-025 ss=1 at posedge (with enable=1): state <= CMD, bit_cnt <= 0, rx_shift <= 0, tx_shift <= 0, miso <= 0, wr_strobe <= 0; ctrl_regs retained; any partial frame is discarded.
REQ-026 enable=0 at posedge: every register holds, including wr_strobe.

Reset
REQ-027 rst_n=0 at posedge sclk takes priority over enable and ss.
REQ-028 Reset values: state CMD, bit_cnt 0, rx_shift 0, tx_shift 0, miso 0, wr_strobe 0, wr_addr 0, registers 1..NUM_REGS-1 0; register 0 always ID_VALUE.
REQ-029 Reset asserted mid-frame or mid-burst aborts the transfer; the first frame after release is a command.

Structure
REQ-030 Package spi_regfile_pkg holds the state enum (CMD, DATA) and the command bit-position constants (RW_BIT, INC_BIT offsets from the MSB).
REQ-031 One sub-module, spi_frame_shifter (rx/tx shift registers, bit counter, frame-done pulse), parametrised by DATA_W; the top module holds the FSM and register file.

Verification (DATA_W=8, NUM_REGS=4, ID_VALUE=8'hA5)
REQ-032 cmd 0x02, data 0x3C -> register 2 = 0x3C; wr_strobe high exactly one sclk; wr_addr = 2.
REQ-033 cmd 0x80, then one dummy frame -> miso carries 0xA5 MSB first, each bit registered one edge after tx_shift load/shift.
REQ-034 cmd 0x43, data 0x11, 0x22, 0x33 -> register 3 = 0x11; 0x22 to address 0 discarded with no strobe; register 1 = 0x33.
REQ-035 ss raised after 5 bits of a frame, then cmd 0x81 plus one data frame -> miso carries register 1; the partial frame has no effect.
REQ-036 rst_n low for one edge mid-burst write -> all registers 1..3 = 0; next frame decoded as a command.
REQ-037 enable low for 3 edges mid-frame -> bit_cnt, shifts and miso frozen; the frame completes correctly after enable returns.
